// File: rtl/multipack_unpacker_pkg.sv
// Shared types for the packed-union unpacker: lane views of a 64-bit word,
// lane modes and the per-mode lane count.
package multipack_pkg;
    localparam int WORD_W     = 64;
    localparam int BYTE_LANES = 8;
    localparam int HALF_LANES = 4;

    typedef struct packed {
        logic [1:0][1:0][1:0] x;
    } elem_t;

    typedef union packed {
        logic [7:0][7:0]  a;
        logic [3:0][15:0] b;
        elem_t [7:0]      c;
    } word_t;

    typedef enum logic [1:0] {
        MODE_BYTE = 2'd0,
        MODE_HALF = 2'd1,
        MODE_ELEM = 2'd2,
        MODE_BAD  = 2'd3
    } lane_mode_e;

    function automatic logic [3:0] lane_count(lane_mode_e m);
        return (m == MODE_HALF) ? 4'(HALF_LANES) : 4'(BYTE_LANES);
    endfunction
endpackage

// File: rtl/multipack_unpacker_if.sv
// Word-in / lane-out handshake bundle for multipack_unpacker.
interface multipack_unpacker_if #(parameter int OUT_W = 16);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [2:0]       out_idx;
    logic             out_last;
    logic             err;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, err
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, err
    );
endinterface

// File: rtl/multipack_unpacker_lane_sel.sv
// Combinational lane picker: reads one lane of a word_t through the union
// view matching the mode, zero-extended to OUT_W.
module multipack_lane_sel
    import multipack_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  word_t            word,
    input  lane_mode_e       mode,
    input  logic [2:0]       idx,
    output logic [OUT_W-1:0] lane
);
    always_comb begin
        lane = '0;
        case (mode)
            MODE_HALF: lane = OUT_W'(word.b[idx[1:0]]);
            MODE_ELEM: lane = OUT_W'(word.c[idx]);
            default:   lane = OUT_W'(word.a[idx]);
        endcase
    end
endmodule

// File: rtl/multipack_unpacker.sv
// Streams one 64-bit word_t out a lane per handshake (byte/half/element view).
// Define MULTIPACK_UNPACK_REVERSE_EN to emit lanes most-significant first.
module multipack_unpacker
    import multipack_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int OUT_W  = 16
) (
    input logic                 clk,
    input logic                 rst,
    multipack_unpacker_if.slave bus
);
    if (ELEM_W * 8 != WORD_W) begin : g_bad_elem_w
        $error("ELEM_W must be 8");
    end
    if (OUT_W < 16) begin : g_bad_out_w
        $error("OUT_W must be at least 16");
    end

    typedef enum logic {IDLE, EMIT} state_e;

    state_e           state;
    word_t            word_q;
    lane_mode_e       mode_q;
    logic [2:0]       idx_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic             out_last_q;
    logic             err_q;

    function automatic logic [2:0] first_idx(lane_mode_e m);
`ifdef MULTIPACK_UNPACK_REVERSE_EN
        return 3'(lane_count(m) - 4'd1);
`else
        return 3'(0 * lane_count(m));
`endif
    endfunction

    function automatic logic [2:0] last_idx(lane_mode_e m);
`ifdef MULTIPACK_UNPACK_REVERSE_EN
        return 3'(0 * lane_count(m));
`else
        return 3'(lane_count(m) - 4'd1);
`endif
    endfunction

    lane_mode_e       in_mode;
    logic             fire, in_ready, acc, load;
    logic [2:0]       step_idx, sel_idx;
    word_t            sel_word;
    lane_mode_e       sel_mode;
    logic [OUT_W-1:0] sel_lane;

    assign in_mode  = lane_mode_e'(bus.in_mode);
    assign fire     = out_valid_q & bus.out_ready;
    // Last-lane handshake reopens the input so a sustained stream has no bubble.
    assign in_ready = (state == IDLE) | (fire & out_last_q);
    assign acc      = bus.in_valid & in_ready;
    assign load     = acc & (in_mode != MODE_BAD);

`ifdef MULTIPACK_UNPACK_REVERSE_EN
    assign step_idx = idx_q - 3'd1;
`else
    assign step_idx = idx_q + 3'd1;
`endif

    // One selector serves both a fresh word and the next lane of the held word.
    assign sel_word = load ? word_t'(bus.in_data) : word_q;
    assign sel_mode = load ? in_mode : mode_q;
    assign sel_idx  = load ? first_idx(in_mode) : step_idx;

    multipack_lane_sel #(.OUT_W(OUT_W)) u_sel (
        .word (sel_word),
        .mode (sel_mode),
        .idx  (sel_idx),
        .lane (sel_lane)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word_q      <= '0;
            mode_q      <= MODE_BYTE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= acc & (in_mode == MODE_BAD);
            if (load) begin
                state       <= EMIT;
                word_q      <= sel_word;
                mode_q      <= in_mode;
                idx_q       <= sel_idx;
                out_valid_q <= 1'b1;
                out_data_q  <= sel_lane;
                out_last_q  <= (sel_idx == last_idx(in_mode));
            end else if (fire) begin
                if (out_last_q) begin
                    state       <= IDLE;
                    idx_q       <= '0;
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                    out_last_q  <= 1'b0;
                end else begin
                    idx_q      <= sel_idx;
                    out_data_q <= sel_lane;
                    out_last_q <= (sel_idx == last_idx(mode_q));
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.err       = err_q;
endmodule
